// File: rtl/chan_select_encoder_if.sv
// Select/enable bus between the channel-select encoder and its decode consumer.
// The encoder uses the master modport and the decode side uses the slave modport.
interface chan_select_encoder_if;
  logic [1:0] key;
  logic [7:0] pend;
  logic       advance;
  logic [2:0] sel;
  logic [1:0] enc_en;
  logic       valid;
  logic       timeout;
  logic [7:0] grant_cnt;

  modport master (
    input  key, pend, advance,
    output sel, enc_en, valid, timeout, grant_cnt
  );

  modport slave (
    output key, pend, advance,
    input  sel, enc_en, valid, timeout, grant_cnt
  );
endinterface

// File: rtl/chan_select_encoder.sv
// Round-robin 8-channel grant encoder driving a 3-bit select and a key-masked enable pair.
// Each grant is held until the consumer advances, the request drops, or the hold timer expires.
module chan_select_encoder #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input logic             clk,
  input logic             rst,
  chan_select_encoder_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        ptr;
  logic [2:0]        sel_q;
  logic [1:0]        key_q;
  logic [TO_W-1:0]   hold;
  logic [7:0]        cnt;
  logic              timeout_q;
  logic [2:0]        winner;
  logic [2:0]        idx;
  logic              found;
  logic              adv_fire;
  logic              wd_fire;
  logic              to_fire;
  logic              valid_c;
  logic [1:0]        enc_en_c;

  // Scan starts one past the last served channel so a busy channel cannot starve the rest.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && bus.pend[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    adv_fire = (state == GRANT) && bus.advance;
    wd_fire  = (state == GRANT) && !bus.advance && !bus.pend[sel_q];
    to_fire  = (state == GRANT) && !bus.advance && bus.pend[sel_q] &&
               (hold == TO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (adv_fire || wd_fire || to_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A withdrawn request leaves ptr alone, so that channel keeps its place in the rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 3'd7;
      sel_q     <= 3'd0;
      key_q     <= 2'b00;
      hold      <= '0;
      cnt       <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel_q <= winner;
            key_q <= bus.key;
            hold  <= '0;
          end
        end
        GRANT: begin
          if (adv_fire) begin
            ptr <= sel_q;
            cnt <= cnt + 8'd1;
          end else if (wd_fire) begin
            hold <= '0;
          end else if (to_fire) begin
            ptr       <= sel_q;
            timeout_q <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_c  = (state == GRANT);
    enc_en_c = valid_c ? key_q : ~bus.key;
  end

  assign bus.valid     = valid_c;
  assign bus.enc_en    = enc_en_c;
  assign bus.sel       = sel_q;
  assign bus.timeout   = timeout_q;
  assign bus.grant_cnt = cnt;

endmodule

// File: tb/tb_chan_select_encoder.sv
// Directed bench for chan_select_encoder: reset, single grant, round robin, timeout,
// conflict resolution, async reset mid-grant and grant counter wrap.
module tb_chan_select_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  chan_select_encoder_if bus ();

  chan_select_encoder #(.TIMEOUT(15), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] pend, input logic [1:0] key, input logic advance);
    bus.pend    = pend;
    bus.key     = key;
    bus.advance = advance;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sel_exp [4] = '{0, 7, 0, 7};

    applyStimulus(8'h00, 2'b10, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.valid), 32'd0);
    checkOutput("rst_sel", 32'(bus.sel), 32'd0);
    checkOutput("rst_enc_en", 32'(bus.enc_en), 32'h1);
    checkOutput("rst_cnt", 32'(bus.grant_cnt), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("idle_valid", 32'(bus.valid), 32'd0);
    checkOutput("idle_timeout", 32'(bus.timeout), 32'd0);

    $display("[TB] single grant");
    applyStimulus(8'h04, 2'b01, 1'b0);
    step();
    checkOutput("sg_valid", 32'(bus.valid), 32'd1);
    checkOutput("sg_sel", 32'(bus.sel), 32'd2);
    checkOutput("sg_enc_en", 32'(bus.enc_en), 32'h1);
    applyStimulus(8'h04, 2'b11, 1'b0);
    #1;
    checkOutput("sg_enc_en_keyhold", 32'(bus.enc_en), 32'h1);
    applyStimulus(8'h04, 2'b11, 1'b1);
    step();
    checkOutput("sg_adv_valid", 32'(bus.valid), 32'd0);
    checkOutput("sg_adv_cnt", 32'(bus.grant_cnt), 32'd1);
    checkOutput("sg_sel_retained", 32'(bus.sel), 32'd2);
    checkOutput("sg_idle_enc_en", 32'(bus.enc_en), 32'h0);
    applyStimulus(8'h00, 2'b11, 1'b0);

    $display("[TB] round robin");
    rst = 1'b1;
    #2;
    applyStimulus(8'h81, 2'b00, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("rr_valid_hi", 32'(bus.valid), 32'd1);
      checkOutput("rr_sel", 32'(bus.sel), 32'(sel_exp[k]));
      checkOutput("rr_enc_en_grant", 32'(bus.enc_en), 32'h0);
      step();
      checkOutput("rr_valid_lo", 32'(bus.valid), 32'd0);
      checkOutput("rr_cnt", 32'(bus.grant_cnt), 32'(k + 1));
      checkOutput("rr_enc_en_idle", 32'(bus.enc_en), 32'h3);
    end

    $display("[TB] timeout");
    applyStimulus(8'h10, 2'b00, 1'b0);
    for (int k = 0; k < 15; k++) begin
      step();
      checkOutput("to_hold_valid", 32'(bus.valid), 32'd1);
      checkOutput("to_hold_sel", 32'(bus.sel), 32'd4);
      checkOutput("to_hold_pulse", 32'(bus.timeout), 32'd0);
    end
    applyStimulus(8'h11, 2'b00, 1'b0);
    step();
    checkOutput("to_pulse", 32'(bus.timeout), 32'd1);
    checkOutput("to_valid", 32'(bus.valid), 32'd0);
    checkOutput("to_cnt", 32'(bus.grant_cnt), 32'd4);
    step();
    checkOutput("to_pulse_end", 32'(bus.timeout), 32'd0);
    checkOutput("to_regrant_valid", 32'(bus.valid), 32'd1);
    checkOutput("to_regrant_sel", 32'(bus.sel), 32'd0);

    $display("[TB] advance on last hold cycle");
    repeat (14) step();
    checkOutput("last_hold_valid", 32'(bus.valid), 32'd1);
    applyStimulus(8'h11, 2'b00, 1'b1);
    step();
    checkOutput("adv_vs_to_pulse", 32'(bus.timeout), 32'd0);
    checkOutput("adv_vs_to_valid", 32'(bus.valid), 32'd0);
    checkOutput("adv_vs_to_cnt", 32'(bus.grant_cnt), 32'd5);
    applyStimulus(8'h11, 2'b00, 1'b0);
    step();
    checkOutput("next_sel", 32'(bus.sel), 32'd4);

    $display("[TB] withdrawal");
    applyStimulus(8'h03, 2'b00, 1'b0);
    step();
    checkOutput("wd_valid", 32'(bus.valid), 32'd0);
    checkOutput("wd_pulse", 32'(bus.timeout), 32'd0);
    checkOutput("wd_cnt", 32'(bus.grant_cnt), 32'd5);
    step();
    checkOutput("wd_ptr_kept_sel", 32'(bus.sel), 32'd1);
    checkOutput("wd_ptr_kept_valid", 32'(bus.valid), 32'd1);

    $display("[TB] async reset mid-grant");
    applyStimulus(8'h20, 2'b01, 1'b1);
    step();
    checkOutput("pre_rst_cnt", 32'(bus.grant_cnt), 32'd6);
    applyStimulus(8'h20, 2'b01, 1'b0);
    step();
    checkOutput("pre_rst_sel", 32'(bus.sel), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(bus.valid), 32'd0);
    checkOutput("arst_sel", 32'(bus.sel), 32'd0);
    checkOutput("arst_cnt", 32'(bus.grant_cnt), 32'd0);
    checkOutput("arst_enc_en", 32'(bus.enc_en), 32'h2);
    #1;
    applyStimulus(8'hFF, 2'b01, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("post_rst_valid", 32'(bus.valid), 32'd1);
    checkOutput("post_rst_sel", 32'(bus.sel), 32'd0);

    $display("[TB] grant counter wrap");
    applyStimulus(8'h01, 2'b01, 1'b1);
    repeat (509) step();
    checkOutput("cnt_255", 32'(bus.grant_cnt), 32'd255);
    repeat (2) step();
    checkOutput("cnt_wrap", 32'(bus.grant_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
